// File: rtl/rtc_edit_bank.sv
// rtc_edit_bank: nine BCD time/date/timer registers for the RTC write sequencer.
// The bank is preloaded from RTC read-back and edited one field at a time with buttons.
module rtc_edit_bank #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  edit_en,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  rd_valid,
    input  logic [6:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic [DATA_WIDTH-1:0] data_out_3,
    output logic [DATA_WIDTH-1:0] data_out_4,
    output logic [DATA_WIDTH-1:0] data_out_5,
    output logic [DATA_WIDTH-1:0] data_out_6,
    output logic [DATA_WIDTH-1:0] data_out_7,
    output logic [DATA_WIDTH-1:0] data_out_8,
    output logic [DATA_WIDTH-1:0] data_out_9,
    output logic [6:0]            counterlr,
    output logic                  commit
);
    localparam int NUM_FIELDS = 9;
    typedef logic [DATA_WIDTH-1:0] byte_t;
    typedef logic [3:0]            idx_t;

    // Fields are stored in cursor order: 33,34,35,36,37,38,65,66,67.
    localparam byte_t RESET_VALS [NUM_FIELDS] =
        '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    function automatic logic [6:0] idx_to_addr(input idx_t idx);
        case (idx)
            4'd0:    return 7'd33;
            4'd1:    return 7'd34;
            4'd2:    return 7'd35;
            4'd3:    return 7'd36;
            4'd4:    return 7'd37;
            4'd5:    return 7'd38;
            4'd6:    return 7'd65;
            4'd7:    return 7'd66;
            default: return 7'd67;
        endcase
    endfunction

    function automatic byte_t field_min(input idx_t idx);
        return (idx == 4'd3 || idx == 4'd4) ? 8'h01 : 8'h00;
    endfunction

    function automatic byte_t field_max(input idx_t idx);
        case (idx)
            4'd2, 4'd8: return 8'h23;
            4'd3:       return 8'h31;
            4'd4:       return 8'h12;
            4'd5:       return 8'h99;
            default:    return 8'h59;
        endcase
    endfunction

    // A byte with a non-decimal nibble or outside the field range snaps to a bound.
    function automatic logic bcd_bad(input byte_t v, input byte_t mn, input byte_t mx);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v < mn) || (v > mx);
    endfunction

    function automatic byte_t bcd_inc(input byte_t v, input byte_t mn, input byte_t mx);
        if (bcd_bad(v, mn, mx) || v == mx) return mn;
        else if (v[3:0] == 4'd9)           return {v[7:4] + 4'd1, 4'd0};
        else                               return v + 8'd1;
    endfunction

    function automatic byte_t bcd_dec(input byte_t v, input byte_t mn, input byte_t mx);
        if (bcd_bad(v, mn, mx) || v == mn) return mx;
        else if (v[3:0] == 4'd0)           return {v[7:4] - 4'd1, 4'd9};
        else                               return v - 8'd1;
    endfunction

    byte_t field_q [NUM_FIELDS];
    byte_t field_d [NUM_FIELDS];
    idx_t  cursor_q, cursor_d;
    logic  up_q, down_q, left_q, right_q, edit_q, commit_q;
    logic  up_rise, down_rise, left_rise, right_rise;
    logic  pre_hit;
    idx_t  pre_idx;

    assign up_rise    = edit_en & btn_up    & ~up_q;
    assign down_rise  = edit_en & btn_down  & ~down_q;
    assign left_rise  = edit_en & btn_left  & ~left_q;
    assign right_rise = edit_en & btn_right & ~right_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pre_hit = 1'b1;
        pre_idx = '0;
        case (rd_addr)
            7'd33:   pre_idx = 4'd0;
            7'd34:   pre_idx = 4'd1;
            7'd35:   pre_idx = 4'd2;
            7'd36:   pre_idx = 4'd3;
            7'd37:   pre_idx = 4'd4;
            7'd38:   pre_idx = 4'd5;
            7'd65:   pre_idx = 4'd6;
            7'd66:   pre_idx = 4'd7;
            7'd67:   pre_idx = 4'd8;
            default: pre_hit = 1'b0;
        endcase
    end

    always_comb begin
        field_d  = field_q;
        cursor_d = cursor_q;
        if (edit_en) begin
            // The value action uses the cursor as it was before any move this cycle.
            if (up_rise && !down_rise)
                field_d[cursor_q] = bcd_inc(field_q[cursor_q], field_min(cursor_q), field_max(cursor_q));
            else if (down_rise && !up_rise)
                field_d[cursor_q] = bcd_dec(field_q[cursor_q], field_min(cursor_q), field_max(cursor_q));
            if (right_rise && !left_rise)
                cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
            else if (left_rise && !right_rise)
                cursor_d = (cursor_q == 4'd0) ? 4'd8 : cursor_q - 4'd1;
        end else if (rd_valid && pre_hit) begin
            field_d[pre_idx] = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; the reset is synchronous and also
        // clears the field bank, which is a handful of flops rather than a RAM.
        if (!reset) begin
            field_q  <= RESET_VALS;
            cursor_q <= 4'd0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            edit_q   <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            field_q  <= field_d;
            cursor_q <= cursor_d;
            up_q     <= btn_up;
            down_q   <= btn_down;
            left_q   <= btn_left;
            right_q  <= btn_right;
            edit_q   <= edit_en;
            commit_q <= edit_q & ~edit_en;
        end
    end

    assign data_out_1 = field_q[0];
    assign data_out_2 = field_q[1];
    assign data_out_3 = field_q[2];
    assign data_out_6 = field_q[3];
    assign data_out_5 = field_q[4];
    assign data_out_4 = field_q[5];
    assign data_out_7 = field_q[6];
    assign data_out_8 = field_q[7];
    assign data_out_9 = field_q[8];
    assign counterlr  = edit_en ? idx_to_addr(cursor_q) : 7'd0;
    assign commit     = commit_q;

endmodule

// File: doc/rtc_edit_bank.md
# rtc_edit_bank

User-edit register bank feeding the RTC write sequencer. It holds the nine BCD time/date/timer bytes that the sequencer writes to the RTC. It also preloads those bytes from RTC read-back and lets the user edit one field at a time with up/down/left/right buttons. Its outputs are the data bytes `data_out_1..9`, the field cursor `counterlr`, and a one-cycle `commit` pulse that tells the top-level controller to start a write sequence.

## Interface
- `DATA_WIDTH`, 8, width of each BCD byte
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `edit_en`  in  1  edit mode; high = buttons active, preload blocked
- `btn_up`  in  1  increment selected field; debounced, level
- `btn_down`  in  1  decrement selected field; debounced, level
- `btn_left`  in  1  move cursor back; debounced, level
- `btn_right`  in  1  move cursor forward; debounced, level
- `rd_valid`  in  1  RTC read-back byte valid
- `rd_addr`  in  7  RTC register address of read-back byte
- `rd_data`  in  8  RTC read-back byte (BCD)
- `data_out_1..data_out_9`  out  8 each  field bytes (see map)
- `counterlr`  out  7  selected RTC register address; 0 when `edit_en` low
- `commit`  out  1  one-cycle pulse on `edit_en` falling edge

## Operation
- Field map, as (address → output, BCD range):
  - 33 → `data_out_1`, seconds, 00–59
  - 34 → `data_out_2`, minutes, 00–59
  - 35 → `data_out_3`, hours, 00–23
  - 36 → `data_out_6`, day, 01–31
  - 37 → `data_out_5`, month, 01–12
  - 38 → `data_out_4`, year, 00–99
  - 65 → `data_out_7`, timer seconds, 00–59
  - 66 → `data_out_8`, timer minutes, 00–59
  - 67 → `data_out_9`, timer hours, 00–23
- Cursor:
  - Internal cursor steps through the sequence 33,34,35,36,37,38,65,66,67.
  - `btn_right` moves it to the next entry; 67 wraps to 33.
  - `btn_left` moves it to the previous entry; 33 wraps to 67.
  - `counterlr` equals the cursor when `edit_en`=1, else 0.
  - The cursor is retained across edit sessions.
- Button handling:
  - Each button is registered once; the action fires on a rising edge (btn=1 and previous sample=0).
  - A held button fires exactly once.
  - Up and down rising in the same cycle: no change to the field.
  - Left and right rising in the same cycle: no cursor move.
  - Value and cursor actions in the same cycle both apply; the value action uses the cursor before the move.
  - All button edges are ignored when `edit_en`=0. Edge-detect registers keep updating regardless of `edit_en`.
- BCD increment on the selected field:
  - If the value is at max, out of range, or has a nibble >9 → range min.
  - Else if the low nibble is 9 → high nibble +1, low nibble 0.
  - Else → low nibble +1.
- BCD decrement on the selected field:
  - If the value is at min, out of range, or has a nibble >9 → range max.
  - Else if the low nibble is 0 → high nibble −1, low nibble 9.
  - Else → low nibble −1.
- Preload:
  - When `edit_en`=0 and `rd_valid`=1, `rd_data` is stored unmodified into the field mapped by `rd_addr`.
  - Unmapped addresses are ignored.
  - `rd_valid` is ignored while `edit_en`=1.
- `commit`: `edit_en` is registered; `commit`=1 for one cycle when the registered value is 1 and the current value is 0.

## Timing
- Reset (`reset`=0 at a clock edge) sets:
  - seconds, minutes, hours, year, and all timer fields to 0x00
  - day and month to 0x01
  - cursor to 33, `counterlr`=0, `commit`=0
  - all edge-detect and `edit_en` registers to 0
- Reset wins over every other input in the same cycle. Reset mid-edit discards all edits and issues no `commit`.
- Latency:
  - A button rising between edges k−1 and k: the field/cursor update is visible after edge k (one cycle).
  - Preload: `rd_data` is visible on the output after the edge that sampled `rd_valid`.
  - `commit` is high for the cycle after the edge that first samples `edit_en`=0.
  - `counterlr` follows `edit_en` combinationally from the registered cursor.
- After reset, the edge detector sees a button already held high as a rising edge. This is intended.

## Test plan
- Reset then idle: all outputs match the reset values; `counterlr`=0; `commit` stays 0 for 10 cycles.
- Preload with `edit_en`=0 (addr 35, 0x21) and (addr 38, 0x24), plus addr 40 → `data_out_3`=0x21, `data_out_4`=0x24, no other field changes. Repeat with `edit_en`=1 → no change.
- `edit_en`=1, cursor 33, seconds=0x58: up pulse → 0x59; held up for 5 cycles → 0x00 once; down → 0x59; down with seconds=0x10 → 0x09.
- Month at 0x12, cursor moved right ×4 to 37 (`counterlr`=37): up → 0x01; down → 0x12. Preloaded 0x1A then up → 0x01. Left from 33 → 67; right from 67 → 33.
- Simultaneous events: up+down together → field unchanged; left+right together → cursor unchanged; up+right together → old field incremented, cursor advances.
- Edit session: `edit_en` 1→0 → `commit` high exactly one cycle and `counterlr`=0. Reset asserted mid-session with edits pending → defaults restored, `commit`=0.
